// File: rtl/adain_pkg.sv
// Shared types and helpers for the AdaIN v2 lane serializer and its lane mux.
package adain_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   localparam int ADAIN_DEFAULT_WIDTH = 16;

   // Width of a lane index for an N-lane word; never narrower than one bit.
   function automatic int lane_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_nto1.sv
// N-to-1 lane mux: selects lane i_sel (WIDTH bits) out of a packed N-lane word.
module mux_nto1
   import adain_pkg::*;
#(
   parameter int N     = 5,
   parameter int WIDTH = ADAIN_DEFAULT_WIDTH
)(
   input  logic [lane_idx_w(N)-1:0] i_sel,
   input  logic [N*WIDTH-1:0]       i_data,
   output logic [WIDTH-1:0]         o_data
);

   always_comb begin
      o_data = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(i_sel) == i) o_data = i_data[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/adain_lane_serializer.sv
// Serializes one N-lane word into N single-lane beats (lane 0 first), valid/ready on both sides.
// Optional ADAIN_SER_COUNT_EN adds s_count to emit only the first s_count lanes of a word.
module adain_lane_serializer
   import adain_pkg::*;
#(
   parameter int N     = 5,
   parameter int WIDTH = ADAIN_DEFAULT_WIDTH
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [N*WIDTH-1:0]       s_data,
   input  logic                     s_last,
`ifdef ADAIN_SER_COUNT_EN
   input  logic [$clog2(N+1)-1:0]   s_count,
`endif
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [WIDTH-1:0]         m_data,
   output logic [lane_idx_w(N)-1:0] m_idx,
   output logic                     m_last,
   output logic                     m_frame_last,
   output ser_state_e               o_dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high; valid never waits on ready, and a presented beat holds until taken.
   localparam int IW = lane_idx_w(N);
   localparam logic [IW-1:0] LAST_LANE_MAX = IW'(N - 1);

   ser_state_e         r_state, w_next_state;
   logic [N*WIDTH-1:0] r_data;
   logic               r_frame_last;
   logic [IW-1:0]      r_idx;
   logic [IW-1:0]      r_last_lane;
   logic [IW-1:0]      w_cap_last_lane;
   logic               w_at_last;
   logic               w_accept;
   logic               w_beat;

`ifdef ADAIN_SER_COUNT_EN
   localparam int CW = $clog2(N + 1);
   // A zero or oversize count falls back to the full word.
   always_comb begin
      if ((s_count == '0) || (s_count > CW'(N))) w_cap_last_lane = LAST_LANE_MAX;
      else                                       w_cap_last_lane = IW'(s_count - CW'(1));
   end
`else
   assign w_cap_last_lane = LAST_LANE_MAX;
`endif

   assign w_at_last = (r_idx == r_last_lane);
   assign w_beat    = (r_state == SHIFT) && m_ready;
   assign s_ready   = (r_state == IDLE) || (w_beat && w_at_last);
   assign w_accept  = s_valid && s_ready;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (s_valid) w_next_state = SHIFT;
         SHIFT:   if (w_beat && w_at_last) w_next_state = s_valid ? SHIFT : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_data       <= '0;
         r_frame_last <= 1'b0;
         r_idx        <= '0;
         r_last_lane  <= LAST_LANE_MAX;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_data       <= s_data;
            r_frame_last <= s_last;
            r_idx        <= '0;
            r_last_lane  <= w_cap_last_lane;
         end else if (w_beat && !w_at_last) begin
            r_idx <= r_idx + IW'(1);
         end
      end
   end

   mux_nto1 #(
      .N     (N),
      .WIDTH (WIDTH)
   ) u_lane_mux (
      .i_sel  (r_idx),
      .i_data (r_data),
      .o_data (m_data)
   );

   assign m_valid      = (r_state == SHIFT);
   assign m_idx        = r_idx;
   assign m_last       = m_valid && w_at_last;
   assign m_frame_last = m_last && r_frame_last;
   assign o_dbg_state  = r_state;

endmodule
